period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock or a sensor pulse, in cycles of the system clock. It checks each measured period against an expected value with a tolerance and reports lock and timeout status. It sits downstream of the frequency-divider chain as its independent checker, and the bottling-line controller uses it to qualify the machine tick before the filling sequence starts.

---
 rtl/period_meter_if.sv | 15 +
 rtl/period_meter.sv | 139 +++++++++++++
 tb/tb_period_meter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// Measurement result bus of period_meter: period/high-time values with
// their update strobe and status flags.
interface period_meter_if #(
  parameter int WIDTH = 28
);
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             in_range;
  logic             timeout;
  logic             locked;

  modport master (output period, high_time, valid, in_range, timeout, locked);
  modport slave  (input  period, high_time, valid, in_range, timeout, locked);
endinterface

// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave, with
// tolerance check, lock qualification and missing-edge timeout.
//
// state | meaning
// IDLE  | after reset, no rising edge seen yet
// ARMED | one reference edge seen, next edge yields a measurement
// RUN   | measuring continuously, every edge yields a measurement
// TMO   | no edge for TIMEOUT cycles, waiting for an edge to re-arm
module period_meter #(
  parameter int WIDTH    = 28,
  parameter int TIMEOUT  = 100_000_000,
  parameter int EXPECTED = 50_000_000,
  parameter int TOL      = 500,
  parameter int LOCK_N   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sig_in,
  period_meter_if.master res
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] TMO   = 2'd3;

  localparam int              LCW      = $clog2(LOCK_N + 1);
  localparam logic [WIDTH-1:0] TMO_CNT = WIDTH'(TIMEOUT);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_N);
  // Range bounds are one bit wider than the counter so EXPECTED+TOL cannot wrap.
  localparam logic [WIDTH:0]  RANGE_LO = (EXPECTED > TOL) ? (WIDTH+1)'(EXPECTED - TOL) : '0;
  localparam logic [WIDTH:0]  RANGE_HI = (WIDTH+1)'(EXPECTED) + (WIDTH+1)'(TOL);

  logic             s1, s2, s3;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic [1:0]       state;
  logic [LCW-1:0]   lock_cnt;
  logic [LCW-1:0]   lock_nxt;
  logic             in_rng;

  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_q;
  logic             valid_q;
  logic             in_range_q;
  logic             timeout_q;
  logic             locked_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise)
        cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      else if (cnt != TMO_CNT)
        cnt <= cnt + 1'b1;

      if (rise)
        hcnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      else if (s2 && (hcnt != {WIDTH{1'b1}}))
        hcnt <= hcnt + 1'b1;
    end
  end

  assign in_rng = ({1'b0, cnt} >= RANGE_LO) && ({1'b0, cnt} <= RANGE_HI);

  always_comb begin
    lock_nxt = '0;
    if (in_rng)
      lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE, ARMED, RUN: begin
          if (rise) begin
            state <= (state == IDLE) ? ARMED : RUN;
            if (state != IDLE) begin
              period_q   <= cnt;
              high_q     <= hcnt;
              in_range_q <= in_rng;
              valid_q    <= 1'b1;
              lock_cnt   <= lock_nxt;
              locked_q   <= (lock_nxt == LOCK_MAX);
            end
          end else if (cnt == TMO_CNT) begin
            // Measured values are kept; only the status is withdrawn.
            state      <= TMO;
            timeout_q  <= 1'b1;
            in_range_q <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt   <= '0;
          end
        end
        default: begin
          if (rise) begin
            state     <= ARMED;
            timeout_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign res.period    = period_q;
  assign res.high_time = high_q;
  assign res.valid     = valid_q;
  assign res.in_range  = in_range_q;
  assign res.timeout   = timeout_q;
  assign res.locked    = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus random periods, checked every
// cycle against an edge-time model of the measurement rules.
module tb_period_meter;

  localparam int W   = 8;
  localparam int TO  = 200;
  localparam int EXP = 50;
  localparam int TOL = 2;
  localparam int LN  = 3;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic sig_in = 1'b0;

  period_meter_if #(.WIDTH(W)) res ();

  period_meter #(
    .WIDTH(W), .TIMEOUT(TO), .EXPECTED(EXP), .TOL(TOL), .LOCK_N(LN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .res    (res)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int checks = 0;
  int errors = 0;

  // Reference model, expressed in edge numbers: a rise first sampled at
  // edge n is reported at edge n+2; timeout fires TO edges after the last
  // counter restart unless a reported rise lands on that same edge.
  int ref_edge, last_n, last_h, pend_n, pend_h, pend_edge, lock_cnt;
  int exp_period, exp_high;
  bit pending, have_prev, tmo_done, in_rst;
  bit exp_valid, exp_inr, exp_locked, exp_tmo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic check_all();
    check("valid",     32'(res.valid),     32'(exp_valid));
    check("period",    32'(res.period),    32'(exp_period));
    check("high_time", 32'(res.high_time), 32'(exp_high));
    check("in_range",  32'(res.in_range),  32'(exp_inr));
    check("timeout",   32'(res.timeout),   32'(exp_tmo));
    check("locked",    32'(res.locked),    32'(exp_locked));
  endtask

  task automatic model_edge();
    int e, d;
    e = edge_no;
    exp_valid = 1'b0;
    if (in_rst) return;
    if (pending && e == pend_edge) begin
      pending = 1'b0;
      if (have_prev) begin
        exp_valid  = 1'b1;
        exp_period = pend_n - last_n;
        exp_high   = last_h;
        d          = (exp_period > EXP) ? exp_period - EXP : EXP - exp_period;
        exp_inr    = (d <= TOL);
        lock_cnt   = exp_inr ? ((lock_cnt < LN) ? lock_cnt + 1 : LN) : 0;
        exp_locked = (lock_cnt == LN);
      end
      have_prev = 1'b1;
      exp_tmo   = 1'b0;
      tmo_done  = 1'b0;
      last_n    = pend_n;
      last_h    = pend_h;
      ref_edge  = e;
    end else if (!tmo_done && e == ref_edge + TO) begin
      tmo_done   = 1'b1;
      exp_tmo    = 1'b1;
      exp_inr    = 1'b0;
      exp_locked = 1'b0;
      lock_cnt   = 0;
      have_prev  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic pulse(input int h, input int l);
    sig_in    = 1'b1;
    pending   = 1'b1;
    pend_n    = edge_no + 1;
    pend_h    = h;
    pend_edge = edge_no + 3;
    for (int k = 1; k <= h + l; k++) begin
      step();
      if (k == h) sig_in = 1'b0;
    end
  endtask

  task automatic idle(input int c);
    for (int k = 0; k < c; k++) step();
  endtask

  task automatic do_reset(input int cyc);
    reset      = 1'b0;
    in_rst     = 1'b1;
    exp_period = 0;
    exp_high   = 0;
    exp_valid  = 1'b0;
    exp_inr    = 1'b0;
    exp_tmo    = 1'b0;
    exp_locked = 1'b0;
    lock_cnt   = 0;
    have_prev  = 1'b0;
    pending    = 1'b0;
    tmo_done   = 1'b0;
    #1;
    check_all();
    for (int k = 0; k < cyc; k++) begin
      step();
      sig_in = ~sig_in;
    end
    sig_in   = 1'b0;
    reset    = 1'b1;
    in_rst   = 1'b0;
    ref_edge = edge_no + 1;
  endtask

  initial begin
    int per, h;
    #2;
    // Reset with a toggling input: outputs stay clear, no valid.
    do_reset(8);
    idle(5);

    // 50/25 square wave: lock on third measurement.
    repeat (4) pulse(25, 25);
    check("lock_period", 32'(res.period), 50);
    check("lock_high",   32'(res.high_time), 25);
    check("lock_inr",    32'(res.in_range), 1);
    check("lock_locked", 32'(res.locked), 1);

    // One 53-cycle period breaks lock, three 49s restore it.
    pulse(25, 28);
    pulse(25, 24);
    check("p53_period", 32'(res.period), 53);
    check("p53_inr",    32'(res.in_range), 0);
    check("p53_locked", 32'(res.locked), 0);
    pulse(25, 24);
    pulse(25, 24);
    pulse(25, 25);
    check("p49_period", 32'(res.period), 49);
    check("p49_locked", 32'(res.locked), 1);

    // Input stops: timeout, then recovery over two rises.
    idle(230);
    check("tmo_flag",   32'(res.timeout), 1);
    check("tmo_locked", 32'(res.locked), 0);
    check("tmo_inr",    32'(res.in_range), 0);
    check("tmo_period", 32'(res.period), 49);
    pulse(25, 25);
    check("tmo_clear",  32'(res.timeout), 0);
    pulse(25, 25);
    check("rearm_period", 32'(res.period), 50);

    // Rise exactly at the timeout count is a valid 200-cycle period.
    pulse(25, 175);
    pulse(25, 25);
    check("p200_period",  32'(res.period), 200);
    check("p200_timeout", 32'(res.timeout), 0);
    // One cycle later is a timeout instead.
    pulse(25, 176);
    pulse(25, 25);
    pulse(25, 25);
    check("p201_period",  32'(res.period), 50);
    check("p201_timeout", 32'(res.timeout), 0);

    // Reset mid-period after lock.
    repeat (4) pulse(25, 25);
    check("pre_rst_locked", 32'(res.locked), 1);
    pulse(25, 12);
    do_reset(3);
    pulse(25, 25);
    pulse(20, 30);
    check("post_rst_period", 32'(res.period), 50);
    check("post_rst_high",   32'(res.high_time), 25);
    check("post_rst_locked", 32'(res.locked), 0);

    // Random periods around nominal with occasional near-timeout gaps.
    repeat (40) begin
      per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(195, 206))
                                        : int'($urandom_range(46, 54));
      h = int'($urandom_range(2, (per - 2 > 100) ? 100 : per - 2));
      pulse(h, per - h);
    end
    idle(210);
    check("final_timeout", 32'(res.timeout), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
